// File: rtl/fetch_ctrl.sv
// fetch_ctrl: in-order instruction fetch with a 2-entry {pc, inst} buffer, redirect flush and program-end halt.
module fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PROG_END = 8'h4C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [7:0]  inst_pc,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [1:0] cnt_q, cnt_d, cnt_kept;
  logic pop, push, redir;
  assign imem_addr = pc_q;
  assign inst_valid = cnt_q != 2'd0;
  assign inst_data = inst_valid ? ins0_q : 32'd0;
  assign inst_pc = inst_valid ? pc0_q : 8'd0;
  assign halted = state_q == DONE;
  always_comb begin
    pop = inst_valid && inst_ready;
    redir = redirect_valid && state_q != DONE;
    push = state_q == FETCH && run && !redir && (cnt_q < 2'd2 || pop);
    cnt_kept = cnt_q - {1'b0, pop};
    pc0_d = pop ? pc1_q : pc0_q;
    ins0_d = pop ? ins1_q : ins0_q;
    pc1_d = pc1_q;
    ins1_d = ins1_q;
    // a push lands in whichever slot is first free after this cycle's pop
    if (push && cnt_kept == 2'd0) begin
      pc0_d = pc_q;
      ins0_d = imem_data;
    end
    if (push && cnt_kept != 2'd0) begin
      pc1_d = pc_q;
      ins1_d = imem_data;
    end
    cnt_d = redir ? 2'd0 : cnt_kept + {1'b0, push};
    pc_d = redir ? (redirect_pc & 8'hFC) : push ? pc_q + 8'd4 : pc_q;
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (run && !redir) ? FETCH : IDLE;
      FETCH: state_d = !run ? IDLE : (push && pc_q == PROG_END) ? DRAIN : FETCH;
      DRAIN: state_d = redir ? FETCH : (cnt_d == 2'd0) ? DONE : DRAIN;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      cnt_q <= 2'd0;
      pc0_q <= 8'd0;
      pc1_q <= 8'd0;
      ins0_q <= 32'd0;
      ins1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      pc0_q <= pc0_d;
      pc1_q <= pc1_d;
      ins0_q <= ins0_d;
      ins1_q <= ins1_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus against a queue-based reference model of the fetch buffer.
module tb_fetch_ctrl;
  localparam logic [7:0] RESET_PC = 8'h00;
  localparam logic [7:0] PROG_END = 8'h4C;
  logic clk = 0, reset = 1, run = 0, redirect_valid = 0, inst_ready = 0;
  logic [7:0] redirect_pc = 0, imem_addr, inst_pc;
  logic [31:0] imem_data, inst_data;
  logic inst_valid, halted;
  int errors = 0, checks = 0, n_acc;
  typedef struct packed {logic [7:0] pc; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic [7:0] m_pc;
  int m_mode;
  fetch_ctrl #(.RESET_PC(RESET_PC), .PROG_END(PROG_END)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(logic [7:0] a);
    logic [5:0] w;
    w = a[7:2];
    return (w == 6'd0) ? 32'h00007033 : (w == 6'd9) ? 32'h404404b3 : (w == 6'd19) ? 32'h03002603 :
           {6'd0, w, 5'd0, 3'd0, w[4:0], 7'h13};
  endfunction
  assign imem_data = rom(imem_addr);
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // mode: 0 idle, 1 fetching, 2 draining after last instruction, 3 done
  task automatic model_edge();
    if (reset) begin
      q.delete();
      m_pc = RESET_PC;
      m_mode = 0;
      return;
    end
    if (q.size() > 0 && inst_ready) void'(q.pop_front());
    if (redirect_valid && m_mode != 3) begin
      q.delete();
      m_pc = {redirect_pc[7:2], 2'b00};
      if (m_mode == 2) m_mode = 1;
      else if (m_mode == 1 && !run) m_mode = 0;
      return;
    end
    case (m_mode)
      0: if (run) m_mode = 1;
      1: if (!run) m_mode = 0;
         else if (q.size() < 2) begin
           q.push_back({m_pc, rom(m_pc)});
           if (m_pc == PROG_END) m_mode = 2;
           m_pc = m_pc + 8'd4;
         end
      2: if (q.size() == 0) m_mode = 3;
      default: ;
    endcase
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", inst_valid, q.size() != 0);
    chk("data", inst_data, q.size() != 0 ? q[0].d : 32'd0);
    chk("pc", inst_pc, q.size() != 0 ? q[0].pc : 8'd0);
    chk("addr", imem_addr, m_pc);
    chk("halted", halted, m_mode == 3);
  endtask
  initial begin
    reset = 1; run = 1; inst_ready = 1; redirect_valid = 1; redirect_pc = 8'h30;
    step(); step();
    chk("rst_addr", imem_addr, 8'h00);
    chk("rst_valid", inst_valid, 0);
    redirect_valid = 0; reset = 0;
    n_acc = 0;
    step();
    chk("lat_k", inst_valid, 0);
    step();
    chk("lat_k1_data", inst_data, 32'h00007033);
    chk("lat_k1_pc", inst_pc, 8'h00);
    for (int i = 0; i < 40 && !halted; i++) begin
      if (inst_valid) n_acc++;
      step();
    end
    chk("halt031", halted, 1);
    chk("halt_valid", inst_valid, 0);
    chk("accepted031", n_acc, 20);
    redirect_valid = 1; redirect_pc = 8'h10;
    step();
    chk("done_ignores_redir", halted, 1);
    redirect_valid = 0; reset = 1; inst_ready = 0;
    step();
    reset = 0;
    step(); step();
    for (int i = 0; i < 5; i++) step();
    chk("stall_addr", imem_addr, 8'h08);
    chk("stall_data", inst_data, 32'h00007033);
    inst_ready = 1;
    step();
    chk("rel1", inst_data, 32'h00100093);
    chk("rel1_pc", inst_pc, 8'h04);
    step();
    chk("rel2", inst_data, 32'h00200113);
    chk("rel2_pc", inst_pc, 8'h08);
    inst_ready = 0;
    step();
    redirect_valid = 1; redirect_pc = 8'h27;
    step();
    chk("redir_valid", inst_valid, 0);
    chk("redir_addr", imem_addr, 8'h24);
    redirect_valid = 0;
    step();
    chk("redir_data", inst_data, 32'h404404b3);
    chk("redir_pc", inst_pc, 8'h24);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 8'h40;
    step();
    chk("redir_pop_valid", inst_valid, 0);
    chk("redir_pop_addr", imem_addr, 8'h40);
    redirect_valid = 0;
    for (int i = 0; i < 12 && !halted; i++) step();
    chk("halt_after_redir", halted, 1);
    reset = 1; step();
    reset = 0; inst_ready = 0;
    step(); step(); step();
    reset = 1;
    step();
    chk("rst2_valid", inst_valid, 0);
    chk("rst2_addr", imem_addr, 8'h00);
    reset = 0; inst_ready = 1;
    step(); step();
    chk("rst2_first", inst_data, 32'h00007033);
    chk("rst2_first_pc", inst_pc, 8'h00);
    redirect_valid = 1; redirect_pc = 8'hFC;
    step();
    chk("wrap_addr0", imem_addr, 8'hFC);
    redirect_valid = 0;
    step();
    chk("wrap_addr1", imem_addr, 8'h00);
    chk("wrap_pc0", inst_pc, 8'hFC);
    step();
    chk("wrap_pc1", inst_pc, 8'h00);
    for (int i = 0; i < 800; i++) begin
      reset = $urandom_range(0, 59) == 0;
      run = $urandom_range(0, 7) != 0;
      inst_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = 8'($urandom_range(0, 255));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, byte address loaded into PC on reset.
REQ-002 SHALL have parameter PROG_END, default 8'h4C, byte address of the last program instruction (word 19).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port run, input, 1, fetch enable.
REQ-006 SHALL have port imem_addr, output, 8, byte address to the instruction memory (word = addr[7:2], combinational read).
REQ-007 SHALL have port imem_data, input, 32, instruction returned the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-009 SHALL have port redirect_pc, input, 8, redirect target byte address.
REQ-010 SHALL have port inst_valid, output, 1, buffer head valid toward decode.
REQ-011 SHALL have port inst_ready, input, 1, decode accepts head.
REQ-012 SHALL have port inst_data, output, 32, head instruction.
REQ-013 SHALL have port inst_pc, output, 8, head instruction byte address.
REQ-014 SHALL have port halted, output, 1, program finished.

Function
REQ-015 SHALL hold an 8-bit PC register; imem_addr = PC at all times.
REQ-016 SHALL hold a 2-entry FIFO of {pc, instruction}; inst_valid = (count != 0); inst_data/inst_pc = head entry, 0 when empty.
REQ-017 SHALL pop when inst_valid && inst_ready; inst_data/inst_pc SHALL stay stable while inst_valid && !inst_ready.
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE: no fetch; run=1 -> FETCH next cycle.
REQ-020 FETCH: fetch when count<2 or a pop occurs this cycle; fetch pushes {PC, imem_data} and sets PC <= PC+4 modulo 256 (0xFC wraps to 0x00).
REQ-021 FETCH: run=0 -> IDLE with no fetch that cycle; buffered entries remain and keep draining.
REQ-022 FETCH: a fetch at PC == PROG_END pushes normally, then -> DRAIN; PC SHALL hold at PROG_END+4.
REQ-023 DRAIN: no fetch; -> DONE on the cycle count becomes 0.
REQ-024 DONE: halted=1, inst_valid=0; stays until reset; redirect ignored.
REQ-025 Redirect (redirect_valid=1 in IDLE, FETCH or DRAIN): flush FIFO (count <= 0); PC <= {redirect_pc[7:2], 2'b00}; no push that cycle; DRAIN -> FETCH; IDLE stays IDLE.
REQ-026 Redirect SHALL take priority over a same-cycle push; a same-cycle pop SHALL still count as accepted by decode.
REQ-027 Steady-state throughput SHALL be one instruction per cycle with inst_ready=1; no entry lost or duplicated under any inst_ready pattern.
REQ-028 Latency: run first sampled high at edge k -> FETCH after edge k; first fetch at edge k+1; inst_valid=1 after edge k+1.

Reset
REQ-029 On reset=1 at a rising edge: PC=RESET_PC, count=0, state=IDLE, inst_valid=0, inst_data=0, inst_pc=0, halted=0, overriding run, redirect, and handshake inputs.
REQ-030 Reset mid-operation SHALL discard buffered entries; no pre-reset entry SHALL appear after reset.

Verification
REQ-031 Reset, run=1, inst_ready=1, default program -> 00007033@00, 00100093@04, 00200113@08 ... 03002603@4C on consecutive cycles; then halted=1, inst_valid=0.
REQ-032 inst_ready=0 for 5 cycles after first valid -> count=2, imem_addr holds 08, inst_data holds 00007033; ready=1 -> 00100093@04 then 00200113@08, none lost or repeated.
REQ-033 Redirect redirect_pc=27 with count=2 -> next cycle inst_valid=0, imem_addr=24; following cycle 404404b3@24; flushed entries never presented.
REQ-034 Redirect and pop in the same cycle -> popped entry accepted once; no push; PC = target.
REQ-035 Reset with count=2 and run=1 held -> next cycle inst_valid=0, imem_addr=00, IDLE; after reset is released, 00007033@00 first.
REQ-036 Redirect to FC with PROG_END=4C -> imem_addr FC then 00; inst_pc sequence FC, 00.
